// File: rtl/brc_pkg.sv
// Shared types and encodings for the ID-stage branch resolution controller.
`default_nettype none

package brc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    RESOLVE = 2'd2
  } brc_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [2:0] F3_BEQ   = 3'b000;
  localparam logic [2:0] F3_BNE   = 3'b001;
  localparam logic [2:0] F3_SLTIU = 3'b011;
  localparam logic [2:0] F3_BLT   = 3'b100;
  localparam logic [2:0] F3_BGE   = 3'b101;
  localparam logic [2:0] F3_BLTU  = 3'b110;
  localparam logic [2:0] F3_BGEU  = 3'b111;

endpackage

`default_nettype wire

// File: rtl/brc_hazard.sv
// Combinational stall-count and forward-select for the two ID-stage operands.
`default_nettype none

module brc_hazard
  import brc_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              i_rs1_used,
  input  logic              i_rs2_used,
  input  logic [REG_AW-1:0] i_rs1_addr,
  input  logic [REG_AW-1:0] i_rs2_addr,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_regwrite,
  input  logic              i_ex_memread,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic              i_mem_regwrite,
  input  logic              i_mem_memread,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic              i_wb_regwrite,
  output logic [1:0]        o_cnt,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b
);

  function automatic logic [1:0] op_stall(input logic live, input logic ex_hit,
                                          input logic ex_load, input logic mem_load_hit);
    if (!live)        return 2'd0;
    if (ex_hit)       return ex_load ? 2'd2 : 2'd1;
    if (mem_load_hit) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [1:0] op_fwd(input logic live, input logic mem_alu_hit,
                                        input logic wb_hit);
    if (!live)       return FWD_RF;
    if (mem_alu_hit) return FWD_MEM;
    if (wb_hit)      return FWD_WB;
    return FWD_RF;
  endfunction

  // x0 is hard-wired zero, so it never needs a stall or a bypass.
  logic live_a, live_b;
  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
  logic [1:0] cnt_a, cnt_b;

  assign live_a    = i_rs1_used && (i_rs1_addr != '0);
  assign live_b    = i_rs2_used && (i_rs2_addr != '0);
  assign ex_hit_a  = i_ex_regwrite  && (i_ex_rd  == i_rs1_addr);
  assign ex_hit_b  = i_ex_regwrite  && (i_ex_rd  == i_rs2_addr);
  assign mem_hit_a = i_mem_regwrite && (i_mem_rd == i_rs1_addr);
  assign mem_hit_b = i_mem_regwrite && (i_mem_rd == i_rs2_addr);
  assign wb_hit_a  = i_wb_regwrite  && (i_wb_rd  == i_rs1_addr);
  assign wb_hit_b  = i_wb_regwrite  && (i_wb_rd  == i_rs2_addr);

  assign cnt_a = op_stall(live_a, ex_hit_a, i_ex_memread, mem_hit_a && i_mem_memread);
  assign cnt_b = op_stall(live_b, ex_hit_b, i_ex_memread, mem_hit_b && i_mem_memread);
  assign o_cnt = (cnt_a >= cnt_b) ? cnt_a : cnt_b;

  assign o_fwd_a = op_fwd(live_a, mem_hit_a && !i_mem_memread, wb_hit_a);
  assign o_fwd_b = op_fwd(live_b, mem_hit_b && !i_mem_memread, wb_hit_b);

endmodule

`default_nettype wire

// File: rtl/brc_ctrl.sv
// ID-stage branch resolution controller: hazard stalls, forwarding, taken/redirect.
// Optional performance counters are enabled with BRC_CTRL_PERF_EN.
`default_nettype none

module brc_ctrl
  import brc_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_br_valid,
  input  logic              i_is_jal,
  input  logic              i_is_jalr,
  input  logic              i_is_slti,
  input  logic [2:0]        i_funct3,
  input  logic [REG_AW-1:0] i_rs1_addr,
  input  logic [REG_AW-1:0] i_rs2_addr,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic              i_ex_regwrite,
  input  logic              i_ex_memread,
  input  logic              i_mem_regwrite,
  input  logic              i_mem_memread,
  input  logic              i_kill,
  input  logic              i_br_less,
  input  logic              i_br_equal,
  output logic              o_br_un,
  output logic              o_slti_sel,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b,
  output logic              o_stall,
  output logic              o_pc_sel,
  output logic              o_flush
`ifdef BRC_CTRL_PERF_EN
  ,
  output logic [31:0]       o_br_cnt,
  output logic [31:0]       o_taken_cnt,
  output logic [31:0]       o_stall_cnt
`endif
);

  brc_state_e        state_q, state_d;
  logic [1:0]        stall_cnt_q, stall_cnt_d;
  logic [REG_AW-1:0] wb_rd_q;
  logic              wb_regwrite_q;

  logic       req, rs1_used, rs2_used, br_taken, taken, decide;
  logic [1:0] haz_cnt, fwd_a, fwd_b;

  assign req      = i_br_valid | i_is_jal | i_is_jalr | i_is_slti;
  assign rs1_used = i_br_valid | i_is_jalr | i_is_slti;
  assign rs2_used = i_br_valid;

  brc_hazard #(.REG_AW(REG_AW)) u_hazard (
    .i_rs1_used     (rs1_used),
    .i_rs2_used     (rs2_used),
    .i_rs1_addr     (i_rs1_addr),
    .i_rs2_addr     (i_rs2_addr),
    .i_ex_rd        (i_ex_rd),
    .i_ex_regwrite  (i_ex_regwrite),
    .i_ex_memread   (i_ex_memread),
    .i_mem_rd       (i_mem_rd),
    .i_mem_regwrite (i_mem_regwrite),
    .i_mem_memread  (i_mem_memread),
    .i_wb_rd        (wb_rd_q),
    .i_wb_regwrite  (wb_regwrite_q),
    .o_cnt          (haz_cnt),
    .o_fwd_a        (fwd_a),
    .o_fwd_b        (fwd_b)
  );

  always_comb begin
    br_taken = 1'b0;
    case (i_funct3)
      F3_BEQ:           br_taken = i_br_equal;
      F3_BNE:           br_taken = !i_br_equal;
      F3_BLT, F3_BLTU:  br_taken = i_br_less;
      F3_BGE, F3_BGEU:  br_taken = !i_br_less;
      default:          br_taken = 1'b0;
    endcase
  end

  assign taken      = i_is_jal | i_is_jalr | (i_br_valid & br_taken);
  assign o_br_un    = i_br_valid ? i_funct3[1] : (i_is_slti && (i_funct3 == F3_SLTIU));
  assign o_slti_sel = i_is_slti;

  // The IDLE cycle itself is the first stall cycle, so STALL covers the remainder.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    o_stall     = 1'b0;
    decide      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (haz_cnt == 2'd0) begin
            decide = 1'b1;
          end else begin
            o_stall     = 1'b1;
            stall_cnt_d = haz_cnt - 2'd1;
            state_d     = (haz_cnt == 2'd1) ? RESOLVE : STALL;
          end
        end
      end
      STALL: begin
        o_stall = 1'b1;
        if (stall_cnt_q <= 2'd1) begin
          stall_cnt_d = 2'd0;
          state_d     = RESOLVE;
        end else begin
          stall_cnt_d = stall_cnt_q - 2'd1;
        end
      end
      RESOLVE: begin
        decide  = req;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (i_kill) begin
      state_d     = IDLE;
      stall_cnt_d = 2'd0;
      o_stall     = 1'b0;
      decide      = 1'b0;
    end
  end

  assign o_pc_sel = decide & taken;
  assign o_flush  = decide & taken;
  assign o_fwd_a  = (state_q == STALL) ? FWD_RF : fwd_a;
  assign o_fwd_b  = (state_q == STALL) ? FWD_RF : fwd_b;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      stall_cnt_q   <= 2'd0;
      wb_rd_q       <= '0;
      wb_regwrite_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      stall_cnt_q   <= stall_cnt_d;
      wb_rd_q       <= i_mem_rd;
      wb_regwrite_q <= i_mem_regwrite;
    end
  end

`ifdef BRC_CTRL_PERF_EN
  logic [31:0] br_cnt_q, taken_cnt_q, stall_cyc_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      br_cnt_q    <= 32'd0;
      taken_cnt_q <= 32'd0;
      stall_cyc_q <= 32'd0;
    end else begin
      if (decide && i_br_valid) br_cnt_q    <= br_cnt_q + 32'd1;
      if (o_pc_sel)             taken_cnt_q <= taken_cnt_q + 32'd1;
      if (o_stall)              stall_cyc_q <= stall_cyc_q + 32'd1;
    end
  end

  assign o_br_cnt    = br_cnt_q;
  assign o_taken_cnt = taken_cnt_q;
  assign o_stall_cnt = stall_cyc_q;
`endif

endmodule

`default_nettype wire
